ccc_reconfig_ctrl: RTL and testbench

CCC_RECONFIG_CTRL -- requirements
Module: ccc_reconfig_ctrl

---
 rtl/ccc_cfg_pkg.sv | 39 +++
 rtl/ccc_cfg_rom.sv | 21 ++
 rtl/ccc_reconfig_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ccc_reconfig_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccc_cfg_pkg.sv
// Shared types and constants for the CCC reconfiguration controller: FSM states,
// profile entry layout and the fixed 4-profile register table.
package ccc_cfg_pkg;

   localparam int APB_AW   = 6;
   localparam int APB_DW   = 8;
   localparam int N_PROF   = 4;
   localparam int MAX_REGS = 8;

   typedef enum logic [3:0] {
      IDLE, BYPASS, ARST, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS,
      RELEASE, WAIT_LOCK, SWITCH, FAIL
   } state_t;

   typedef struct packed {
      logic [APB_AW-1:0] addr;
      logic [APB_DW-1:0] data;
      logic [APB_DW-1:0] mask;
   } cfg_entry_t;

   typedef cfg_entry_t [N_PROF-1:0][MAX_REGS-1:0] cfg_table_t;

   // Profile p occupies addresses p*16+i; data is 0x11*(i+1) with p in the top two bits.
   // Profiles 1 and 3 only verify one nibble on readback.
   function automatic cfg_table_t build_table();
      cfg_table_t t;
      for (int p = 0; p < N_PROF; p++) begin
         for (int i = 0; i < MAX_REGS; i++) begin
            t[p][i].addr = APB_AW'(p * 16 + i);
            t[p][i].data = 8'(17 * (i + 1)) ^ {2'(p), 6'b0};
            t[p][i].mask = (p == 1) ? 8'h0F : (p == 3) ? 8'hF0 : 8'hFF;
         end
      end
      return t;
   endfunction

   localparam cfg_table_t CFG_TABLE = build_table();

endpackage

// File: rtl/ccc_cfg_rom.sv
// Combinational profile table lookup; indices at or beyond N_REGS return zero.
module ccc_cfg_rom
   import ccc_cfg_pkg::*;
#(
   parameter int N_REGS = 8,
   localparam int IW    = $clog2(N_REGS + 1)
) (
   input  logic [1:0]    profile,
   input  logic [IW-1:0] index,
   output cfg_entry_t    entry
);

   localparam int TIW = $clog2(MAX_REGS);

   always_comb begin
      entry = '0;
      if (index < IW'(N_REGS))
         entry = CFG_TABLE[profile][TIW'(index)];
   end

endmodule

// File: rtl/ccc_reconfig_ctrl.sv
// CCC PLL reconfiguration sequencer: bypass the clock, hold the PLL in reset, write and
// verify a register profile over APB, release reset, wait for stable lock, switch back.
module ccc_reconfig_ctrl
   import ccc_cfg_pkg::*;
#(
   parameter int N_REGS       = 8,
   parameter int ARST_CYCLES  = 16,
   parameter int LOCK_STABLE  = 8,
   parameter int LOCK_TIMEOUT = 4096
) (
   input  logic              PCLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [1:0]        CFG_SEL,
   input  logic              LOCK,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [APB_AW-1:0] PADDR,
   output logic [APB_DW-1:0] PWDATA,
   input  logic [APB_DW-1:0] PRDATA,
   output logic              PLL_ARST_N,
   output logic              NGMUX_SEL,
   output logic              GL_VALID
);

   localparam int BYPASS_CYCLES = 4;
   localparam int CMAX = (ARST_CYCLES > BYPASS_CYCLES) ? ARST_CYCLES : BYPASS_CYCLES;
   localparam int IW   = $clog2(N_REGS + 1);
   localparam int CW   = $clog2(CMAX + 1);
   localparam int SW   = $clog2(LOCK_STABLE + 1);
   localparam int TW   = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [IW-1:0] LAST = IW'(N_REGS - 1);

   state_t          state;
   logic [1:0]      cfg;
   logic [IW-1:0]   idx, lk_idx;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   scnt, scnt_n;
   logic [TW-1:0]   tcnt, tcnt_n;
   logic [APB_DW-1:0] rd_mask;
   logic            rd_bad;
   cfg_entry_t      entry;

   // The APB outputs are registered, so the table is addressed with the entry the
   // next setup cycle will present rather than the one currently on the bus.
   always_comb begin
      lk_idx = idx;
      if (state == WR_ACCESS)
         lk_idx = (idx == LAST) ? '0 : idx + 1'b1;
      else if (state == RD_ACCESS && idx != LAST)
         lk_idx = idx + 1'b1;
      scnt_n = LOCK ? ((scnt == SW'(LOCK_STABLE)) ? scnt : scnt + 1'b1) : '0;
      tcnt_n = (tcnt == TW'(LOCK_TIMEOUT)) ? tcnt : tcnt + 1'b1;
      rd_bad = |((PRDATA ^ PWDATA) & rd_mask);
   end

   ccc_cfg_rom #(.N_REGS(N_REGS)) u_rom (
      .profile (cfg),
      .index   (lk_idx),
      .entry   (entry)
   );

   always_ff @(posedge PCLK) begin
      if (RESET) begin
         state      <= IDLE;
         cfg        <= '0;
         idx        <= '0;
         cnt        <= '0;
         scnt       <= '0;
         tcnt       <= '0;
         rd_mask    <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ERR        <= 1'b0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         PLL_ARST_N <= 1'b1;
         NGMUX_SEL  <= 1'b0;
         GL_VALID   <= 1'b0;
      end else begin
         DONE     <= 1'b0;
         GL_VALID <= (state == IDLE) && LOCK;
         case (state)
            IDLE, FAIL: if (START) begin
               cfg       <= CFG_SEL;
               ERR       <= 1'b0;
               BUSY      <= 1'b1;
               NGMUX_SEL <= 1'b1;
               cnt       <= '0;
               state     <= BYPASS;
            end
            BYPASS: if (cnt == CW'(BYPASS_CYCLES - 1)) begin
               cnt        <= '0;
               idx        <= '0;
               PLL_ARST_N <= 1'b0;
               state      <= ARST;
            end else begin
               cnt <= (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
            end
            ARST: if (cnt == CW'(ARST_CYCLES - 1)) begin
               PSEL   <= 1'b1;
               PWRITE <= 1'b1;
               PADDR  <= entry.addr;
               PWDATA <= entry.data;
               state  <= WR_SETUP;
            end else begin
               cnt <= (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
            end
            WR_SETUP: begin
               PENABLE <= 1'b1;
               state   <= WR_ACCESS;
            end
            WR_ACCESS: begin
               PENABLE <= 1'b0;
               PADDR   <= entry.addr;
               PWDATA  <= entry.data;
               idx     <= lk_idx;
               if (idx == LAST) begin
                  PWRITE  <= 1'b0;
                  rd_mask <= entry.mask;
                  state   <= RD_SETUP;
               end else begin
                  state <= WR_SETUP;
               end
            end
            RD_SETUP: begin
               PENABLE <= 1'b1;
               state   <= RD_ACCESS;
            end
            RD_ACCESS: begin
               PENABLE <= 1'b0;
               if (rd_bad) begin
                  PSEL      <= 1'b0;
                  ERR       <= 1'b1;
                  BUSY      <= 1'b0;
                  NGMUX_SEL <= 1'b1;
                  state     <= FAIL;
               end else if (idx == LAST) begin
                  PSEL       <= 1'b0;
                  PLL_ARST_N <= 1'b1;
                  state      <= RELEASE;
               end else begin
                  idx     <= lk_idx;
                  PADDR   <= entry.addr;
                  PWDATA  <= entry.data;
                  rd_mask <= entry.mask;
                  state   <= RD_SETUP;
               end
            end
            RELEASE: begin
               scnt  <= '0;
               tcnt  <= '0;
               state <= WAIT_LOCK;
            end
            WAIT_LOCK: begin
               scnt <= scnt_n;
               tcnt <= tcnt_n;
               // Stability is tested first so it wins a same-cycle tie with the timeout.
               if (scnt_n == SW'(LOCK_STABLE)) begin
                  NGMUX_SEL <= 1'b0;
                  DONE      <= 1'b1;
                  BUSY      <= 1'b0;
                  state     <= SWITCH;
               end else if (tcnt_n == TW'(LOCK_TIMEOUT)) begin
                  ERR        <= 1'b1;
                  BUSY       <= 1'b0;
                  PLL_ARST_N <= 1'b0;
                  state      <= FAIL;
               end
            end
            SWITCH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// Scoreboard bench for ccc_reconfig_ctrl: expected APB transfers are queued by the
// stimulus and popped by a monitor on every access cycle.
module tb_ccc_reconfig_ctrl;

   logic       PCLK = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b0;
   logic [1:0] CFG_SEL = 2'd0;
   logic       LOCK = 1'b0;
   logic       BUSY, DONE, ERR, PSEL, PENABLE, PWRITE;
   logic [5:0] PADDR;
   logic [7:0] PWDATA, PRDATA;
   logic       PLL_ARST_N, NGMUX_SEL, GL_VALID;

   ccc_reconfig_ctrl dut (
      .PCLK(PCLK), .RESET(RESET), .START(START), .CFG_SEL(CFG_SEL), .LOCK(LOCK),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PLL_ARST_N(PLL_ARST_N), .NGMUX_SEL(NGMUX_SEL), .GL_VALID(GL_VALID)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      logic       wr;
      logic [5:0] addr;
      logic [7:0] data;
   } xfer_t;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     rd_cnt  = 0;
   int     done_cnt = 0;
   xfer_t  exp_q[$];
   xfer_t  setup_x, got_x, exp_x;

   // Hand-written profile data; address of entry i in profile p is p*16+i.
   logic [7:0] pdata [4][8] = '{
      '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88},
      '{8'h51, 8'h62, 8'h73, 8'h04, 8'h15, 8'h26, 8'h37, 8'hC8},
      '{8'h91, 8'hA2, 8'hB3, 8'hC4, 8'hD5, 8'hE6, 8'hF7, 8'h08},
      '{8'hD1, 8'hE2, 8'hF3, 8'h84, 8'h95, 8'hA6, 8'hB7, 8'h48}
   };

   // Register model that echoes writes, optionally flipping bit 0 at one address.
   logic [7:0] mem [64] = '{default: 8'h00};
   logic       corrupt_en = 1'b0;
   logic [5:0] corrupt_addr = 6'd0;
   assign PRDATA = mem[PADDR] ^ ((corrupt_en && PADDR == corrupt_addr) ? 8'h01 : 8'h00);
   always @(posedge PCLK) if (!RESET && PSEL && PENABLE && PWRITE) mem[PADDR] <= PWDATA;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge PCLK) begin
      if (!RESET) begin
         if (DONE) done_cnt++;
         if (PSEL && !PENABLE) setup_x = '{PWRITE, PADDR, PWDATA};
         if (PSEL && PENABLE) begin
            got_x = '{PWRITE, PADDR, PWDATA};
            check("setup_stable", 32'(got_x), 32'(setup_x));
            if (!PWRITE) rd_cnt++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_xfer: got %0h expected none", got_x);
            end else begin
               exp_x = exp_q.pop_front();
               check("apb_xfer", 32'(got_x), 32'(exp_x));
            end
         end
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] sel);
      START = 1'b1;
      CFG_SEL = sel;
      tick();
      START = 1'b0;
   endtask

   task automatic push_prof(input int p, input int nwr, input int nrd);
      for (int i = 0; i < nwr; i++) exp_q.push_back('{1'b1, 6'(p * 16 + i), pdata[p][i]});
      for (int i = 0; i < nrd; i++) exp_q.push_back('{1'b0, 6'(p * 16 + i), pdata[p][i]});
   endtask

   // which: 0 DONE, 1 PLL_ARST_N low, 2 PLL_ARST_N high, 3 ERR, 4 write-5 access, 5 any write access
   task automatic wait_for(input int which, input int budget, input string name, output int cyc);
      bit hit;
      hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < budget) begin
         tick();
         cyc++;
         case (which)
            0: hit = DONE;
            1: hit = !PLL_ARST_N;
            2: hit = PLL_ARST_N;
            3: hit = ERR;
            4: hit = PSEL && PENABLE && PWRITE && PADDR == 6'd5;
            default: hit = PSEL && PENABLE && PWRITE;
         endcase
      end
      if (!hit) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no event within %0d cycles", name, budget);
         cyc = -1;
      end
   endtask

   initial begin
      int cyc, byp, ar;
      logic [3:0] chatter;
      chatter = 4'b1110;

      // Reset state
      repeat (3) tick();
      check("rst_busy", 32'(BUSY), 0);
      check("rst_done_err", 32'({DONE, ERR}), 0);
      check("rst_apb_ctl", 32'({PSEL, PENABLE, PWRITE}), 0);
      check("rst_apb_bus", 32'({PADDR, PWDATA}), 0);
      check("rst_arst_n", 32'(PLL_ARST_N), 1);
      check("rst_ngmux_gl", 32'({NGMUX_SEL, GL_VALID}), 0);
      RESET = 1'b0;
      tick();

      // GL_VALID follows LOCK in IDLE with one cycle of latency
      LOCK = 1'b1;
      tick();
      check("gl_valid_on", 32'(GL_VALID), 1);
      LOCK = 1'b0;
      tick();
      check("gl_valid_off", 32'(GL_VALID), 0);

      // Nominal, profile 2
      done_cnt = 0;
      push_prof(2, 8, 8);
      pulse_start(2'd2);
      check("start_busy_ngmux", 32'({BUSY, NGMUX_SEL, PLL_ARST_N}), 32'b111);
      byp = 0;
      while (PLL_ARST_N && byp < 10) begin byp++; tick(); end
      check("bypass_cycles", 32'(byp), 4);
      ar = 0;
      while (!PSEL && ar < 40) begin ar++; tick(); end
      check("arst_cycles", 32'(ar), 16);
      wait_for(2, 100, "nom_release", cyc);
      repeat (50) tick();
      LOCK = 1'b1;
      wait_for(0, 40, "nom_done", cyc);
      check("nom_lock_to_done", 32'(cyc), 8);
      check("nom_end_state", 32'({NGMUX_SEL, BUSY, ERR, GL_VALID}), 0);
      tick();
      check("nom_done_pulse", 32'(DONE), 0);
      check("nom_done_cnt", 32'(done_cnt), 1);
      check("nom_queue_empty", 32'(exp_q.size()), 0);

      // START while busy with a different profile is ignored
      push_prof(1, 8, 8);
      pulse_start(2'd1);
      wait_for(5, 60, "busy_wr_access", cyc);
      pulse_start(2'd3);
      wait_for(0, 200, "busy_done", cyc);
      check("busy_err", 32'(ERR), 0);
      tick();
      check("busy_queue_empty", 32'(exp_q.size()), 0);

      // Lock chatter, profile 0
      LOCK = 1'b0;
      done_cnt = 0;
      push_prof(0, 8, 8);
      pulse_start(2'd0);
      wait_for(1, 20, "chat_arst", cyc);
      wait_for(2, 100, "chat_release", cyc);
      for (int r = 0; r < 5; r++)
         for (int k = 3; k >= 0; k--) begin
            LOCK = chatter[k];
            tick();
         end
      check("chat_no_done", 32'(done_cnt), 0);
      LOCK = 1'b1;
      wait_for(0, 40, "chat_done", cyc);
      check("chat_rise_to_done", 32'(cyc), 8);
      tick();

      // Readback mismatch at read 3 of profile 0
      corrupt_en = 1'b1;
      corrupt_addr = 6'd3;
      rd_cnt = 0;
      push_prof(0, 8, 4);
      pulse_start(2'd0);
      wait_for(3, 200, "mis_err", cyc);
      check("mis_fail_state", 32'({ERR, PLL_ARST_N, BUSY, NGMUX_SEL, PSEL}), 32'b10010);
      repeat (5) tick();
      check("mis_rd_cnt", 32'(rd_cnt), 4);
      check("mis_queue_empty", 32'(exp_q.size()), 0);
      corrupt_en = 1'b0;

      // Lock timeout, restarting from FAIL
      LOCK = 1'b0;
      push_prof(2, 8, 8);
      pulse_start(2'd2);
      check("to_start_clears_err", 32'({ERR, BUSY}), 32'b01);
      wait_for(1, 20, "to_arst", cyc);
      wait_for(2, 100, "to_release", cyc);
      tick();
      wait_for(3, 5000, "to_err", cyc);
      check("to_cycles", 32'(cyc), 4096);
      check("to_fail_state", 32'({PLL_ARST_N, NGMUX_SEL, BUSY}), 32'b010);
      LOCK = 1'b1;
      done_cnt = 0;
      push_prof(3, 8, 8);
      pulse_start(2'd3);
      check("rec_err_clear", 32'(ERR), 0);
      wait_for(0, 200, "rec_done", cyc);
      tick();
      check("rec_done_err", 32'({done_cnt[1:0], ERR}), 32'b010);
      check("rec_queue_empty", 32'(exp_q.size()), 0);

      // Reset during the access cycle of write 5
      LOCK = 1'b0;
      push_prof(0, 5, 0);
      pulse_start(2'd0);
      wait_for(4, 60, "rst_wr5", cyc);
      RESET = 1'b1;
      tick();
      check("mid_rst_apb", 32'({PSEL, PENABLE}), 0);
      check("mid_rst_ctl", 32'({PLL_ARST_N, BUSY, NGMUX_SEL, DONE, ERR}), 32'b10000);
      RESET = 1'b0;
      tick();
      check("mid_rst_idle", 32'({PSEL, BUSY}), 0);
      check("mid_rst_queue", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
